// File: rtl/maxnet_pkg.sv
// rtl/maxnet_pkg.sv - shared constants, state encoding and helpers for the maxnet engine
package maxnet_pkg;

    localparam int          MAXNET_DW   = 32;
    localparam int          MAXNET_FRAC = 16;
    localparam logic [31:0] MAXNET_EPS  = 32'h0000_2000;

    localparam logic [31:0] ONE  = 32'h0001_0000;
    localparam logic [31:0] ZERO = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SUM    = 3'd2,
        UPDATE = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Negative activations are clamped to zero on entry
    function automatic logic [MAXNET_DW-1:0] relu(input logic signed [MAXNET_DW-1:0] v);
        return v[MAXNET_DW-1] ? ZERO : v;
    endfunction

endpackage

// File: rtl/maxnet_if.sv
// rtl/maxnet_if.sv - request/result bundle between the maxnet engine and its neighbours
interface maxnet_if #(
    parameter int DW = maxnet_pkg::MAXNET_DW,
    parameter int IW = 7
);
    logic          start;
    logic [DW-1:0] in1, in2, in3, in4;
    logic          busy;
    logic          done;
    logic [DW-1:0] x1, x2, x3, x4;
    logic [DW-1:0] a1, a2, a3, a4;
    logic          ch1, ch2, ch3, ch4;
    logic [IW-1:0] iter_cnt;
    logic          timeout;

    modport master (
        output start, in1, in2, in3, in4,
        input  busy, done, x1, x2, x3, x4, a1, a2, a3, a4,
        input  ch1, ch2, ch3, ch4, iter_cnt, timeout
    );

    modport slave (
        input  start, in1, in2, in3, in4,
        output busy, done, x1, x2, x3, x4, a1, a2, a3, a4,
        output ch1, ch2, ch3, ch4, iter_cnt, timeout
    );
endinterface

// File: rtl/maxnet_pe.sv
// rtl/maxnet_pe.sv - one neuron's lateral-inhibition update
module maxnet_pe #(
    parameter int DW   = 32,
    parameter int FRAC = 16,
    parameter int SW   = DW + 2
) (
    input  logic signed [DW-1:0] a,
    input  logic signed [SW-1:0] s,
    input  logic        [DW-1:0] eps,
    output logic signed [DW-1:0] a_next,
    output logic                 nz
);
    localparam int PW = SW + DW;

    logic signed [SW-1:0] diff;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] p;
    logic signed [PW-1:0] a_ext;

    // Inhibition is eps times the sum of the other three neurons; clamp at zero
    always_comb begin
        diff   = s - SW'(a);
        prod   = $signed({{(PW-SW){diff[SW-1]}}, diff}) * $signed({{(PW-DW){1'b0}}, eps});
        p      = prod >>> FRAC;
        a_ext  = PW'(a);
        a_next = (p > a_ext) ? '0 : a - p[DW-1:0];
        nz     = |a_next;
    end
endmodule

// File: rtl/maxnet_core.sv
// rtl/maxnet_core.sv - iterative 4-neuron maxnet winner-take-all engine
module maxnet_core
    import maxnet_pkg::*;
#(
    parameter int            DW       = MAXNET_DW,
    parameter int            FRAC     = MAXNET_FRAC,
    parameter logic [DW-1:0] EPS      = MAXNET_EPS,
    parameter int            MAX_ITER = 64,
    parameter int            IW       = 7
) (
    input logic     clk,
    input logic     rst_n,
    maxnet_if.slave bus
);
    localparam int SW = DW + 2;

    localparam logic [2:0] ST_IDLE   = IDLE;
    localparam logic [2:0] ST_LOAD   = LOAD;
    localparam logic [2:0] ST_SUM    = SUM;
    localparam logic [2:0] ST_UPDATE = UPDATE;
    localparam logic [2:0] ST_DONE   = DONE;

    logic [2:0]           state_q;
    logic signed [DW-1:0] a_q    [4];
    logic signed [DW-1:0] x_q    [4];
    logic signed [DW-1:0] a_next [4];
    logic signed [DW-1:0] in_w   [4];
    logic [3:0]           ch_q;
    logic [3:0]           nz;
    logic signed [SW-1:0] sum_q;
    logic [IW-1:0]        iter_q;
    logic [IW-1:0]        iter_inc;
    logic                 timeout_q;
    logic                 multi;

    assign in_w[0] = bus.in1;
    assign in_w[1] = bus.in2;
    assign in_w[2] = bus.in3;
    assign in_w[3] = bus.in4;

    for (genvar i = 0; i < 4; i++) begin : g_pe
        maxnet_pe #(.DW(DW), .FRAC(FRAC), .SW(SW)) u_pe (
            .a      (a_q[i]),
            .s      (sum_q),
            .eps    (EPS),
            .a_next (a_next[i]),
            .nz     (nz[i])
        );
    end

    // Two or more survivors after this update means another iteration is needed
    assign multi    = |(nz & (nz - 4'd1));
    assign iter_inc = iter_q + 1'b1;

    // Sequencer: load, then alternate sum/update until a single winner or the cap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sum_q     <= '0;
            iter_q    <= '0;
            timeout_q <= 1'b0;
            ch_q      <= '0;
            for (int i = 0; i < 4; i++) begin
                a_q[i] <= '0;
                x_q[i] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        for (int i = 0; i < 4; i++) begin
                            x_q[i]  <= relu(in_w[i]);
                            a_q[i]  <= relu(in_w[i]);
                            ch_q[i] <= |relu(in_w[i]);
                        end
                        iter_q    <= '0;
                        timeout_q <= 1'b0;
                        state_q   <= ST_LOAD;
                    end
                end
                ST_LOAD: state_q <= ST_SUM;
                ST_SUM: begin
                    sum_q   <= SW'(a_q[0]) + SW'(a_q[1]) + SW'(a_q[2]) + SW'(a_q[3]);
                    state_q <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    for (int i = 0; i < 4; i++) begin
                        a_q[i] <= a_next[i];
                    end
                    ch_q   <= nz;
                    iter_q <= iter_inc;
                    if (!multi) begin
                        state_q <= ST_DONE;
                    end else if (iter_inc == IW'(MAX_ITER)) begin
                        timeout_q <= 1'b1;
                        state_q   <= ST_DONE;
                    end else begin
                        state_q <= ST_SUM;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy     = (state_q == ST_LOAD) || (state_q == ST_SUM) || (state_q == ST_UPDATE);
    assign bus.done     = (state_q == ST_DONE);
    assign bus.x1       = x_q[0];
    assign bus.x2       = x_q[1];
    assign bus.x3       = x_q[2];
    assign bus.x4       = x_q[3];
    assign bus.a1       = a_q[0];
    assign bus.a2       = a_q[1];
    assign bus.a3       = a_q[2];
    assign bus.a4       = a_q[3];
    assign bus.ch1      = ch_q[0];
    assign bus.ch2      = ch_q[1];
    assign bus.ch3      = ch_q[2];
    assign bus.ch4      = ch_q[3];
    assign bus.iter_cnt = iter_q;
    assign bus.timeout  = timeout_q;
endmodule

// File: tb/tb_maxnet_core.sv
// tb/tb_maxnet_core.sv - self-checking bench for maxnet_core
module tb_maxnet_core;

    localparam longint EPS_Q = 64'h2000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    maxnet_if #(.DW(32), .IW(7)) bus0 ();
    maxnet_if #(.DW(32), .IW(7)) bus1 ();

    maxnet_core #(.MAX_ITER(64)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    maxnet_core #(.MAX_ITER(2))  dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    logic        start_v [2];
    logic [31:0] in_v    [2][4];
    logic [31:0] d_a     [2][4];
    logic [31:0] d_x     [2][4];
    logic [3:0]  d_ch    [2];
    logic [6:0]  d_it    [2];
    logic        d_busy  [2];
    logic        d_done  [2];
    logic        d_tmo   [2];

    assign bus0.start = start_v[0];
    assign bus0.in1 = in_v[0][0];
    assign bus0.in2 = in_v[0][1];
    assign bus0.in3 = in_v[0][2];
    assign bus0.in4 = in_v[0][3];
    assign bus1.start = start_v[1];
    assign bus1.in1 = in_v[1][0];
    assign bus1.in2 = in_v[1][1];
    assign bus1.in3 = in_v[1][2];
    assign bus1.in4 = in_v[1][3];

    assign d_a[0] = '{bus0.a1, bus0.a2, bus0.a3, bus0.a4};
    assign d_x[0] = '{bus0.x1, bus0.x2, bus0.x3, bus0.x4};
    assign d_a[1] = '{bus1.a1, bus1.a2, bus1.a3, bus1.a4};
    assign d_x[1] = '{bus1.x1, bus1.x2, bus1.x3, bus1.x4};
    assign d_ch[0] = {bus0.ch1, bus0.ch2, bus0.ch3, bus0.ch4};
    assign d_ch[1] = {bus1.ch1, bus1.ch2, bus1.ch3, bus1.ch4};
    assign d_it[0] = bus0.iter_cnt;
    assign d_it[1] = bus1.iter_cnt;
    assign d_busy[0] = bus0.busy;
    assign d_busy[1] = bus1.busy;
    assign d_done[0] = bus0.done;
    assign d_done[1] = bus1.done;
    assign d_tmo[0] = bus0.timeout;
    assign d_tmo[1] = bus1.timeout;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] got %h expected %h at %0t", name, inst, act, exp, $time);
        end
    endtask

    // Behavioural model: the whole trajectory is planned at acceptance, outputs follow from elapsed cycles
    int     max_it [2] = '{64, 2};
    bit     run    [2];
    longint t0     [2];
    int     n_it   [2];
    bit     tmo    [2];
    longint xr     [2][4];
    longint traj   [2][65][4];
    longint cyc = 0;

    task automatic plan(input int inst);
        longint s, p, na;
        int cnt, nzc;
        for (int j = 0; j < 4; j++) begin
            xr[inst][j] = longint'($signed(in_v[inst][j]));
            if (xr[inst][j] < 0) xr[inst][j] = 0;
            traj[inst][0][j] = xr[inst][j];
        end
        cnt = 0;
        tmo[inst] = 1'b0;
        while (1) begin
            s = 0;
            for (int j = 0; j < 4; j++) s += traj[inst][cnt][j];
            nzc = 0;
            for (int j = 0; j < 4; j++) begin
                p  = ((s - traj[inst][cnt][j]) * EPS_Q) / 65536;
                na = traj[inst][cnt][j] - p;
                if (na < 0) na = 0;
                traj[inst][cnt+1][j] = na;
                if (na != 0) nzc++;
            end
            cnt++;
            if (nzc < 2) break;
            if (cnt == max_it[inst]) begin
                tmo[inst] = 1'b1;
                break;
            end
        end
        n_it[inst] = cnt;
    endtask

    // Model acceptance: idle unless within the start..DONE window of the current run
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run[0] = 1'b0;
            run[1] = 1'b0;
        end else begin
            cyc++;
            for (int inst = 0; inst < 2; inst++) begin
                if (start_v[inst] && (!run[inst] || (cyc - t0[inst]) >= longint'(2 * n_it[inst] + 3))) begin
                    plan(inst);
                    t0[inst]  = cyc;
                    run[inst] = 1'b1;
                end
            end
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        for (int inst = 0; inst < 2; inst++) begin
            automatic longint e_a [4] = '{0, 0, 0, 0};
            automatic longint e_x [4] = '{0, 0, 0, 0};
            automatic logic [3:0] e_ch = 4'b0000;
            automatic int e_it = 0;
            automatic logic e_busy = 1'b0;
            automatic logic e_done = 1'b0;
            automatic logic e_tmo = 1'b0;
            automatic longint k = 0;
            if (run[inst]) begin
                k = cyc - t0[inst];
                e_it = (k == 0) ? 0 : int'((k - 1) / 2);
                if (e_it > n_it[inst]) e_it = n_it[inst];
                for (int j = 0; j < 4; j++) begin
                    e_a[j] = traj[inst][e_it][j];
                    e_x[j] = xr[inst][j];
                    e_ch[3-j] = (e_a[j] != 0);
                end
                e_tmo  = tmo[inst] && (e_it == n_it[inst]);
                e_busy = (k <= longint'(2 * n_it[inst]));
                e_done = (k == longint'(2 * n_it[inst] + 1));
            end
            for (int j = 0; j < 4; j++) begin
                chk("a", inst, d_a[inst][j], e_a[j]);
                chk("x", inst, d_x[inst][j], e_x[j]);
                chk("a_nonneg", inst, d_a[inst][j][31], 0);
            end
            chk("ch", inst, d_ch[inst], e_ch);
            chk("iter_cnt", inst, d_it[inst], e_it);
            chk("busy", inst, d_busy[inst], e_busy);
            chk("done", inst, d_done[inst], e_done);
            chk("timeout", inst, d_tmo[inst], e_tmo);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int inst, input int lim);
        int k;
        k = 0;
        while (!d_done[inst] && k < lim) begin
            step();
            k++;
        end
        if (!d_done[inst]) chk("wait_done", inst, d_done[inst], 1);
    endtask

    initial begin
        start_v = '{1'b0, 1'b0};
        in_v[0] = '{32'h0, 32'h0, 32'h0, 32'h0};
        in_v[1] = '{32'h0, 32'h0, 32'h0, 32'h0};
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("rst_busy", 0, d_busy[0], 0);
        chk("rst_a1", 0, d_a[0][0], 0);

        // Graded inputs: 1.0, 0.5, 0.25, 0.125
        in_v[0] = '{32'h0001_0000, 32'h0000_8000, 32'h0000_4000, 32'h0000_2000};
        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        chk("lit_busy_k0", 0, d_busy[0], 1);
        chk("lit_x1", 0, d_x[0][0], 32'h0001_0000);
        repeat (3) step();
        chk("lit_it1_a1", 0, d_a[0][0], 32'h0000_E400);
        chk("lit_it1_a2", 0, d_a[0][1], 32'h0000_5400);
        chk("lit_it1_a3", 0, d_a[0][2], 32'h0000_0C00);
        chk("lit_it1_a4", 0, d_a[0][3], 32'h0000_0000);
        in_v[0] = '{32'h0000_1234, 32'h0000_1234, 32'h0000_1234, 32'h0000_1234};
        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        step();
        chk("lit_it2_a1", 0, d_a[0][0], 32'h0000_D800);
        chk("lit_it2_a2", 0, d_a[0][1], 32'h0000_3600);
        chk("lit_it2_a3", 0, d_a[0][2], 32'h0000_0000);
        repeat (6) step();
        chk("lit_done_k11", 0, d_done[0], 1);
        chk("lit_iter5", 0, d_it[0], 5);
        chk("lit_ch1000", 0, d_ch[0], 4'b1000);
        chk("lit_tmo0", 0, d_tmo[0], 0);
        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        chk("lit_ignored_busy", 0, d_busy[0], 0);
        repeat (3) step();
        chk("lit_hold_a1", 0, d_a[0][0], 32'h0000_CDC5);
        chk("lit_hold_x1", 0, d_x[0][0], 32'h0001_0000);

        // Negative input clamps; start held high is re-accepted after DONE
        in_v[0] = '{32'hFFFF_0000, 32'h0000_8000, 32'h0, 32'h0};
        start_v[0] = 1'b1;
        step();
        chk("lit_relu_x1", 0, d_x[0][0], 0);
        chk("lit_relu_a1", 0, d_a[0][0], 0);
        repeat (3) step();
        chk("lit_b_done_k3", 0, d_done[0], 1);
        chk("lit_b_iter1", 0, d_it[0], 1);
        chk("lit_b_a2", 0, d_a[0][1], 32'h0000_8000);
        chk("lit_b_ch0100", 0, d_ch[0], 4'b0100);
        step();
        chk("lit_b_idle", 0, d_busy[0], 0);
        step();
        chk("lit_b_reaccept", 0, d_busy[0], 1);
        start_v[0] = 1'b0;
        wait_done(0, 20);
        step();

        // Exact tie: decays symmetrically to a fixed point, then hits the cap
        in_v[0] = '{32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'h0000_8000};
        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        wait_done(0, 400);
        chk("lit_tie_tmo", 0, d_tmo[0], 1);
        chk("lit_tie_iter", 0, d_it[0], 64);
        chk("lit_tie_ch", 0, d_ch[0], 4'b1111);
        chk("lit_tie_a1", 0, d_a[0][0], 32'h2);
        step();

        // Reset mid-iteration, then a normal run
        in_v[0] = '{32'h0001_0000, 32'h0000_8000, 32'h0000_4000, 32'h0000_2000};
        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        repeat (6) step();
        rst_n = 1'b0;
        #1;
        chk("lit_rst_busy", 0, d_busy[0], 0);
        chk("lit_rst_a1", 0, d_a[0][0], 0);
        step();
        rst_n = 1'b1;
        step();
        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        wait_done(0, 40);
        chk("lit_rerun_iter", 0, d_it[0], 5);
        chk("lit_rerun_a1", 0, d_a[0][0], 32'h0000_CDC5);

        // Iteration cap of 2
        in_v[1] = '{32'h0001_0000, 32'h0000_FF00, 32'h0, 32'h0};
        start_v[1] = 1'b1;
        step();
        start_v[1] = 1'b0;
        repeat (3) step();
        chk("lit_cap_it1_a1", 1, d_a[1][0], 32'h0000_E020);
        chk("lit_cap_it1_a2", 1, d_a[1][1], 32'h0000_DF00);
        wait_done(1, 20);
        chk("lit_cap_iter", 1, d_it[1], 2);
        chk("lit_cap_tmo", 1, d_tmo[1], 1);
        chk("lit_cap_ch", 1, d_ch[1], 4'b1100);
        chk("lit_cap_a1", 1, d_a[1][0], 32'h0000_C440);
        chk("lit_cap_a2", 1, d_a[1][1], 32'h0000_C2FC);
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
